tabla_perf_monitor: RTL and testbench
=====================================

# tabla_perf_monitor

Cycle-accurate performance monitor for one accelerator job. It observes the memory-interface/accelerator handshake signals (compute_start, EOI, EOC, the write-back last beat) and the per-lane AXI-HP read and write beat strobes. It produces the read, processing, write and total cycle counters and the phase-done flags that the control register file exposes over AXIS_GP0. It sits beside mem_interface, consuming the signals it exchanges with the accelerator, and feeds the control slave.

## Interface
- PERF_CNTR_WIDTH, 10: width of every cycle and beat counter.
- NUM_AXI, 4: number of AXI-HP lanes (beat strobe vector width).
- clk  in  1: sole clock; all logic is on the rising edge.
- reset_in  in  1: synchronous, active-high reset.
- compute_start  in  1: job start pulse from the control slave.
- eol  in  1: end of input load (EOI).
- eoc  in  1: end of compute (EOC).
- wr_last  in  1: final write-back beat accepted on the AXI-HP write channel.
- rd_beat  in  NUM_AXI: per-lane RVALID&RREADY.
- wr_beat  in  NUM_AXI: per-lane WVALID&WREADY.
- rd_cycles, pr_cycles, wr_cycles, total_cycles  out  PERF_CNTR_WIDTH each: phase cycle counts.
- rd_beats, wr_beats  out  PERF_CNTR_WIDTH each: accepted beat totals over all lanes.
- rd_done, processing_done, wr_done  out  1 each: sticky phase-complete flags.
- busy  out  1: state is not IDLE.
- done  out  1: one-cycle job-complete pulse.
- overrun  out  1: sticky; a compute_start arrived while busy.

## Operation
- FSM states: IDLE, LOAD, COMPUTE, WRITE, DONE.
- IDLE, compute_start=1:
  - Clear all counters, done flags and overrun.
  - Go to LOAD.
- LOAD:
  - eol=1 → COMPUTE, set rd_done.
  - eol=1 and eoc=1 in the same cycle → WRITE directly, set rd_done and processing_done.
- COMPUTE: eoc=1 → WRITE, set processing_done.
- WRITE: wr_last=1 → DONE, set wr_done.
- DONE: done=1 for this cycle only, then → IDLE unconditionally.
- eol, eoc and wr_last are ignored in any state other than the one listed above.
- compute_start outside IDLE, including DONE:
  - Ignored for sequencing.
  - Sets overrun; overrun is cleared only by reset or by an accepted start.
- Cycle counters:
  - rd_cycles increments on every edge where state==LOAD.
  - pr_cycles increments on every edge where state==COMPUTE.
  - wr_cycles increments on every edge where state==WRITE.
  - total_cycles increments on every edge where state is LOAD, COMPUTE or WRITE.
- Beat counters:
  - Add the popcount of rd_beat (or wr_beat) every cycle, in any state including IDLE.
  - Cleared only by reset and by an accepted start.
- Arithmetic:
  - All counters saturate at 2^PERF_CNTR_WIDTH−1 and never wrap.
  - The beat-counter sum is computed one bit wider, then clamped.
- Counters and flags hold their values after DONE until the next accepted start, so software can read them.

## Timing
- Reset: state=IDLE; every output is 0.
- Reset asserted mid-job wins over all other inputs and aborts the job with no done pulse.
- All outputs are registered; a change caused by an input sampled at edge N is visible after edge N.
- Start sampled at edge N, eol sampled at edge N+k → rd_cycles=k.
- pr_cycles and wr_cycles follow the same rule for their phases.
- total_cycles = rd_cycles+pr_cycles+wr_cycles whenever none of them has saturated.
- Start clearing takes priority over a beat arriving on the same edge; that beat is not counted.
- done is high for exactly one cycle, one edge after the wr_last sample.
- busy drops in that same cycle.
- Minimum job length: start → LOAD (1) → WRITE (1, eol & eoc together) → DONE (1).

## Configuration
- TABLA_PERF_BEAT_CNT_EN defined: rd_beats and wr_beats are implemented as described above.
- Undefined:
  - No beat adders or registers are built.
  - rd_beats and wr_beats are constant 0.
  - rd_beat and wr_beat are unused.
  - All other behaviour is unchanged.

## Test plan
- Basic job: reset; start at edge 0, eol at 6, eoc at 16, wr_last at 20 → rd=6, pr=10, wr=4, total=20, done high one cycle after edge 20, all three done flags set.
- Collapsed phase: eol and eoc both high at edge 3 after start at 0 → pr_cycles=0, processing_done=1, state WRITE.
- Saturation and beats (with PERF_BEAT_CNT_EN, PERF_CNTR_WIDTH=4):
  - rd_beat=4'b1111 for 5 cycles → rd_beats=15, no wrap.
  - LOAD held 20 cycles → rd_cycles=15.
- Overrun: start pulses at edges 0 and 3 → job timing unchanged, overrun=1; the next start in IDLE clears overrun and all counters.
- Reset mid-WRITE: reset_in high at one edge → all outputs 0, state IDLE, no done pulse; a following start runs normally.
- Macro off: rd_beat=4'b1111 held 10 cycles → rd_beats=0; cycle counters match the basic job.

Source files
------------

// File: rtl/tabla_perf_monitor.sv
// tabla_perf_monitor: cycle and beat performance monitor for one accelerator job.
// It tracks the job phases LOAD -> COMPUTE -> WRITE -> DONE from the
// compute_start / EOI / EOC / write-back-last handshake, and keeps saturating
// per-phase cycle counters plus sticky phase-done flags for the control slave.
// Optional feature macro: TABLA_PERF_BEAT_CNT_EN builds the AXI-HP read/write
// beat totals. Without it, rd_beats/wr_beats are tied to 0.
//
// Handshake semantics: the inputs are single-cycle qualifiers sampled on the
// rising edge. compute_start is honoured only in IDLE. eol is honoured only in
// LOAD, eoc only in LOAD (together with eol) or COMPUTE, and wr_last only in
// WRITE. There is no back-pressure; the monitor never stalls its sources.
// state_dbg exposes the FSM state for observation (0=IDLE, 1=LOAD,
// 2=COMPUTE, 3=WRITE, 4=DONE).
module tabla_perf_monitor #(
  parameter int PERF_CNTR_WIDTH = 10,
  parameter int NUM_AXI         = 4
) (
  input  logic                       clk,
  input  logic                       reset_in,
  input  logic                       compute_start,
  input  logic                       eol,
  input  logic                       eoc,
  input  logic                       wr_last,
  input  logic [NUM_AXI-1:0]         rd_beat,
  input  logic [NUM_AXI-1:0]         wr_beat,
  output logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] wr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] total_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] rd_beats,
  output logic [PERF_CNTR_WIDTH-1:0] wr_beats,
  output logic                       rd_done,
  output logic                       processing_done,
  output logic                       wr_done,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  output logic [2:0]                 state_dbg
);

  localparam int W = PERF_CNTR_WIDTH;
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state;
  logic   start_accept;

  assign start_accept = (state == S_IDLE) && compute_start;
  assign state_dbg    = state;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Job sequencer: phase transitions, sticky flags, busy/done and overrun.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state           <= S_IDLE;
      rd_done         <= 1'b0;
      processing_done <= 1'b0;
      wr_done         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (compute_start) begin
            state           <= S_LOAD;
            rd_done         <= 1'b0;
            processing_done <= 1'b0;
            wr_done         <= 1'b0;
            busy            <= 1'b1;
            overrun         <= 1'b0;
          end
        end
        S_LOAD: begin
          if (eol && eoc) begin
            state           <= S_WRITE;
            rd_done         <= 1'b1;
            processing_done <= 1'b1;
          end else if (eol) begin
            state   <= S_COMPUTE;
            rd_done <= 1'b1;
          end
        end
        S_COMPUTE: begin
          if (eoc) begin
            state           <= S_WRITE;
            processing_done <= 1'b1;
          end
        end
        S_WRITE: begin
          if (wr_last) begin
            state   <= S_DONE;
            wr_done <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
      // A start outside IDLE (DONE included) never restarts the job; it is
      // only remembered so software can see it lost a request.
      if (compute_start && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Phase cycle counters: count edges spent in each phase, cleared by a start.
  always_ff @(posedge clk) begin
    if (reset_in || start_accept) begin
      rd_cycles    <= '0;
      pr_cycles    <= '0;
      wr_cycles    <= '0;
      total_cycles <= '0;
    end else begin
      if (state == S_LOAD)    rd_cycles <= sat_inc(rd_cycles);
      if (state == S_COMPUTE) pr_cycles <= sat_inc(pr_cycles);
      if (state == S_WRITE)   wr_cycles <= sat_inc(wr_cycles);
      if ((state == S_LOAD) || (state == S_COMPUTE) || (state == S_WRITE)) begin
        total_cycles <= sat_inc(total_cycles);
      end
    end
  end

`ifdef TABLA_PERF_BEAT_CNT_EN
  // Number of set lanes, produced one bit wider than the counters so it can
  // be added to a counter value without losing the carry.
  function automatic logic [W:0] popcnt(input logic [NUM_AXI-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < NUM_AXI; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [W:0] rd_sum;
  logic [W:0] wr_sum;

  assign rd_sum = {1'b0, rd_beats} + popcnt(rd_beat);
  assign wr_sum = {1'b0, wr_beats} + popcnt(wr_beat);

  // Beat totals accumulate in every state; a start clears them and drops
  // any beat landing on the same edge. Overflow clamps to all-ones.
  always_ff @(posedge clk) begin
    if (reset_in || start_accept) begin
      rd_beats <= '0;
      wr_beats <= '0;
    end else begin
      rd_beats <= rd_sum[W] ? CNT_MAX : rd_sum[W-1:0];
      wr_beats <= wr_sum[W] ? CNT_MAX : wr_sum[W-1:0];
    end
  end
`else
  logic unused_beat_inputs;

  assign unused_beat_inputs = ^{rd_beat, wr_beat};
  assign rd_beats = '0;
  assign wr_beats = '0;
`endif

endmodule

// File: tb/tb_tabla_perf_monitor.sv
// tb_tabla_perf_monitor: randomized self-checking bench for tabla_perf_monitor.
// Jobs are planned as phase lengths (load, compute, write). Expected counter
// values follow directly from those lengths. Beat totals come from a running
// saturating sum of lane popcounts.
module tb_tabla_perf_monitor;

  localparam int W    = 10;
  localparam int NA   = 4;
  localparam int MAXV = (1 << W) - 1;

  // clock / reset block
  logic          clk = 1'b0;
  logic          reset_in;
  logic          compute_start, eol, eoc, wr_last;
  logic [NA-1:0] rd_beat, wr_beat;
  logic [W-1:0]  rd_cycles, pr_cycles, wr_cycles, total_cycles, rd_beats, wr_beats;
  logic          rd_done, processing_done, wr_done, busy, done, overrun;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  tabla_perf_monitor #(.PERF_CNTR_WIDTH(W), .NUM_AXI(NA)) dut (
    .clk(clk), .reset_in(reset_in), .compute_start(compute_start),
    .eol(eol), .eoc(eoc), .wr_last(wr_last),
    .rd_beat(rd_beat), .wr_beat(wr_beat),
    .rd_cycles(rd_cycles), .pr_cycles(pr_cycles), .wr_cycles(wr_cycles),
    .total_cycles(total_cycles), .rd_beats(rd_beats), .wr_beats(wr_beats),
    .rd_done(rd_done), .processing_done(processing_done), .wr_done(wr_done),
    .busy(busy), .done(done), .overrun(overrun), .state_dbg(state_dbg)
  );

  // scoreboard
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];
`ifdef TABLA_PERF_BEAT_CNT_EN
  bit beat_en = 1'b1;
`else
  bit beat_en = 1'b0;
`endif
  int m_rdb = 0;
  int m_wrb = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // driver tasks
  task automatic step(input logic st, input logic eo, input logic ec, input logic wl,
                      input logic [NA-1:0] rb, input logic [NA-1:0] wb, input bit clr);
    compute_start = st; eol = eo; eoc = ec; wr_last = wl;
    rd_beat = rb; wr_beat = wb;
    @(posedge clk);
    #1;
    if (clr) begin
      m_rdb = 0;
      m_wrb = 0;
    end else if (beat_en) begin
      m_rdb = sat(m_rdb + $countones(rb));
      m_wrb = sat(m_wrb + $countones(wb));
    end
  endtask

  function automatic logic [NA-1:0] rnd_lanes();
    return NA'($urandom_range(0, (1 << NA) - 1));
  endfunction

  task automatic do_reset(input string tag);
    reset_in = 1'b1;
    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
         rnd_lanes(), rnd_lanes(), 1'b1);
    reset_in = 1'b0;
    check({tag, "_cycles"}, {rd_cycles, pr_cycles, wr_cycles}, 0);
    check({tag, "_total"}, total_cycles, 0);
    check({tag, "_beats"}, {rd_beats, wr_beats}, 0);
    check({tag, "_flags"}, {rd_done, processing_done, wr_done, busy, done, overrun}, 0);
    check({tag, "_state_idle"}, state_dbg, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), rnd_lanes(), rnd_lanes(), 1'b0);
    end
    check("idle_busy_done", {busy, done}, 0);
    check("idle_beats", {rd_beats, wr_beats}, {W'(m_rdb), W'(m_wrb)});
  endtask

  // One job: start at edge 0, eol at edge a, eoc at edge a+b (with eol when
  // b==0), wr_last at edge a+b+c; DONE occupies the following edge.
  task automatic run_job(input int a, input int b, input int c, input bit noise,
                         input int start_pct, input int extra_start, input bit ones);
    int total;
    bit exp_ovr;
    bit early_done;
    logic st, eo, ec, wl;
    logic [NA-1:0] rb, wb;
    total = a + b + c;
    exp_ovr = 1'b0;
    early_done = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, ones ? '1 : rnd_lanes(), rnd_lanes(), 1'b1);
    check("start_busy", busy, 1);
    check("start_clear_cycles", {rd_cycles, pr_cycles, wr_cycles, total_cycles}, 0);
    check("start_clear_beats", {rd_beats, wr_beats}, 0);
    check("start_clear_flags", {rd_done, processing_done, wr_done, done, overrun}, 0);
    for (int e = 1; e <= total + 1; e++) begin
      st = (e == extra_start) ||
           ((start_pct > 0) && ($urandom_range(0, 99) < start_pct));
      if (st) exp_ovr = 1'b1;
      eo = (e == a);
      ec = (e == a + b);
      wl = (e == total);
      if (noise) begin
        if (e < a) begin
          ec = 1'($urandom_range(0, 1)); wl = 1'($urandom_range(0, 1));
        end else if ((e > a) && (e < a + b)) begin
          eo = 1'($urandom_range(0, 1)); wl = 1'($urandom_range(0, 1));
        end else if ((e > a + b) && (e < total)) begin
          eo = 1'($urandom_range(0, 1)); ec = 1'($urandom_range(0, 1));
        end else if (e == total + 1) begin
          eo = 1'($urandom_range(0, 1)); ec = 1'($urandom_range(0, 1));
          wl = 1'($urandom_range(0, 1));
        end
      end
      rb = ones ? '1 : rnd_lanes();
      wb = rnd_lanes();
      step(st, eo, ec, wl, rb, wb, 1'b0);
      if ((e < total) && (done || !busy)) early_done = 1'b1;
      if (e == a) begin
        check("eol_rd_cycles", rd_cycles, sat(a));
        check("eol_flags", {rd_done, processing_done, wr_done}, {1'b1, (b == 0), 1'b0});
      end
      if (e == total) begin
        check("job_early_done", early_done, 0);
        check("job_done_pulse", {done, busy}, 2'b10);
        check("job_flags", {rd_done, processing_done, wr_done}, 3'b111);
        exp_q.push_back(W'(sat(a)));
        exp_q.push_back(W'(sat(b)));
        exp_q.push_back(W'(sat(c)));
        exp_q.push_back(W'(sat(total)));
        exp_q.push_back(W'(m_rdb));
        exp_q.push_back(W'(m_wrb));
        check("rd_cycles", rd_cycles, exp_q.pop_front());
        check("pr_cycles", pr_cycles, exp_q.pop_front());
        check("wr_cycles", wr_cycles, exp_q.pop_front());
        check("total_cycles", total_cycles, exp_q.pop_front());
        check("rd_beats", rd_beats, exp_q.pop_front());
        check("wr_beats", wr_beats, exp_q.pop_front());
      end
      if (e == total + 1) begin
        check("after_done_pulse", {done, busy}, 0);
        check("overrun", overrun, exp_ovr);
        check("hold_cycles", {rd_cycles, total_cycles}, {W'(sat(a)), W'(sat(total))});
        check("hold_flags", {rd_done, processing_done, wr_done}, 3'b111);
        check("hold_beats", {rd_beats, wr_beats}, {W'(m_rdb), W'(m_wrb)});
      end
    end
  endtask

  // stimulus
  initial begin
    reset_in = 1'b0; compute_start = 1'b0; eol = 1'b0; eoc = 1'b0; wr_last = 1'b0;
    rd_beat = '0; wr_beat = '0;
    @(posedge clk); #1;
    do_reset("reset");
    idle_cycles(3);

    run_job(6, 10, 4, 1'b0, 0, -1, 1'b0);    // basic job
    idle_cycles(2);
    run_job(3, 0, 3, 1'b0, 0, -1, 1'b0);     // eol and eoc together
    run_job(6, 4, 2, 1'b0, 0, 3, 1'b0);      // second start mid-job
    run_job(2, 2, 2, 1'b0, 0, 7, 1'b0);      // start during DONE
    run_job(1, 0, 1, 1'b0, 0, -1, 1'b0);     // minimum job

    // reset mid-WRITE with wr_last on the reset edge
    step(1'b1, 1'b0, 1'b0, 1'b0, rnd_lanes(), rnd_lanes(), 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, rnd_lanes(), rnd_lanes(), 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, rnd_lanes(), rnd_lanes(), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, rnd_lanes(), rnd_lanes(), 1'b0);
    check("midwrite_busy", busy, 1);
    do_reset("midwrite_reset");
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    check("midwrite_no_done", {done, busy, wr_done}, 0);
    run_job(5, 3, 2, 1'b1, 0, -1, 1'b0);

    // long load with every read lane active: counters clamp at all-ones
    run_job(1100, 2, 1, 1'b0, 0, -1, 1'b1);

    for (int j = 0; j < 10; j++) begin
      run_job($urandom_range(1, 20), $urandom_range(0, 15), $urandom_range(1, 10),
              1'b1, 8, -1, 1'b0);
      idle_cycles($urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
